// File: rtl/bslu_ap_pkg.sv
// Shared definitions for the BSLU associative-processing micro-op sequencer.
// Holds register one-hot codes, op bit positions, the packed uop layout and FSM states.
// Legality helper is used only when BSLU_AP_SEQ_ILLEGAL_CHK_EN is defined.
package bslu_ap_pkg;

  // One-hot register selects for the three BSLU registers
  localparam logic [2:0] REG_SA = 3'b001;
  localparam logic [2:0] REG_CR = 3'b010;
  localparam logic [2:0] REG_PR = 3'b100;

  // Bit positions inside the 6-bit op field
  localparam int OP_MOV    = 0;
  localparam int OP_SET    = 1;
  localparam int OP_SETVAL = 2;
  localparam int OP_AND    = 3;
  localparam int OP_XNOR   = 4;
  localparam int OP_SEL    = 5;

  // Micro-op word layout: {rs1[14:12], rs2[11:9], rd[8:6], op[5:0]}
  localparam int UOP_W       = 15;
  localparam int UOP_RS1_LSB = 12;
  localparam int UOP_RS2_LSB = 9;
  localparam int UOP_RD_LSB  = 6;
  localparam int UOP_OP_LSB  = 0;
  localparam int UOP_REG_W   = 3;
  localparam int UOP_OP_W    = 6;

  typedef struct packed {
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [2:0] rd;
    logic [5:0] op;
  } uop_t;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  // Entry is legal when rd names exactly one register and at most one
  // exclusive operation bit is set (SETVAL is a modifier, not an operation).
  function automatic logic uop_legal(input uop_t u);
    logic       rd_ok;
    logic [2:0] n_exec;
    rd_ok  = (u.rd == REG_SA) || (u.rd == REG_CR) || (u.rd == REG_PR);
    n_exec = 3'(u.op[OP_MOV]) + 3'(u.op[OP_SET]) + 3'(u.op[OP_AND]) +
             3'(u.op[OP_XNOR]) + 3'(u.op[OP_SEL]);
    return rd_ok && (n_exec <= 3'd1);
  endfunction

endpackage

// File: rtl/bslu_ap_seq_if.sv
// Bundle of program-write, command and micro-op broadcast signals of the sequencer.
// No logic; master is the front-end/array side, slave is the sequencer.
// Command handshake is valid/ready; the uop stream is throttled by stall.
interface bslu_ap_seq_if
  import bslu_ap_pkg::*;
#(
  parameter int PC_W   = 4,
  parameter int ITER_W = 6
) ();
  logic              prog_we;
  logic [PC_W-1:0]   prog_addr;
  logic [UOP_W-1:0]  prog_data;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [PC_W-1:0]   cmd_start_pc;
  logic [PC_W-1:0]   cmd_end_pc;
  logic [ITER_W-1:0] cmd_iters;
  logic              stall;
  logic              uop_valid;
  logic [2:0]        uop_rs1;
  logic [2:0]        uop_rs2;
  logic [2:0]        uop_rd;
  logic [5:0]        uop_op;
  logic [ITER_W-1:0] bit_idx;
  logic              done;
  logic              err;

  modport master (
    output prog_we, prog_addr, prog_data,
    output cmd_valid, cmd_start_pc, cmd_end_pc, cmd_iters, stall,
    input  cmd_ready, uop_valid, uop_rs1, uop_rs2, uop_rd, uop_op,
    input  bit_idx, done, err
  );

  modport slave (
    input  prog_we, prog_addr, prog_data,
    input  cmd_valid, cmd_start_pc, cmd_end_pc, cmd_iters, stall,
    output cmd_ready, uop_valid, uop_rs1, uop_rs2, uop_rd, uop_op,
    output bit_idx, done, err
  );
endinterface

// File: rtl/bslu_ap_ustore.sv
// Micro-program store: 2**PC_W x 15-bit register file, not reset.
// Write lands on the clock edge; read is combinational on raddr.
// No backpressure; a write is accepted every cycle prog_we is high.
module bslu_ap_ustore
  import bslu_ap_pkg::*;
#(
  parameter int PC_W = 4
) (
  input  logic            clk,
  input  logic            we,
  input  logic [PC_W-1:0] waddr,
  input  uop_t            wdata,
  input  logic [PC_W-1:0] raddr,
  output uop_t            rdata
);
  localparam int DEPTH = 2 ** PC_W;

  uop_t mem_q [DEPTH];
  uop_t mem_d [DEPTH];

  // Next contents: copy of current store with the addressed entry replaced on write
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // Store register; contents deliberately survive reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/bslu_ap_seq.sv
// Micro-op sequencer: replays store[start..end] once per bit-slice, cmd_iters times.
// Latency: first uop one cycle after command accept; done one cycle after the last uop.
// stall sampled at a clock edge blanks the next cycle's uop and freezes pc/iter.
// Optional illegal-entry check enabled by defining BSLU_AP_SEQ_ILLEGAL_CHK_EN.
module bslu_ap_seq
  import bslu_ap_pkg::*;
#(
  parameter int PC_W   = 4,
  parameter int ITER_W = 6
) (
  input logic         clk,
  input logic         rst,
  bslu_ap_seq_if.slave bus
);
  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [PC_W-1:0]   start_q, start_d;
  logic [PC_W-1:0]   end_q, end_d;
  logic [ITER_W-1:0] iters_q, iters_d;
  logic              last_q, last_d;
  logic              uop_vld_q, uop_vld_d;
  uop_t              uop_q, uop_d;
  logic [ITER_W-1:0] bit_idx_q, bit_idx_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [PC_W-1:0]   cur_pc;
  logic [ITER_W-1:0] cur_iter;
  uop_t              entry;
  logic              legal;
  logic              issue;

  // In IDLE the store is addressed by the incoming command so the first uop
  // can be registered on the accept edge itself.
  assign cur_pc   = (state_q == IDLE) ? bus.cmd_start_pc : pc_q;
  assign cur_iter = (state_q == IDLE) ? '0 : iter_q;

  bslu_ap_ustore #(.PC_W(PC_W)) u_ustore (
    .clk   (clk),
    .we    (bus.prog_we),
    .waddr (bus.prog_addr),
    .wdata (uop_t'(bus.prog_data)),
    .raddr (cur_pc),
    .rdata (entry)
  );

`ifdef BSLU_AP_SEQ_ILLEGAL_CHK_EN
  assign legal = uop_legal(entry);
`else
  assign legal = 1'b1;
`endif

  // Next-state and next-output computation; op is forced to NOP unless issuing
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    iter_d    = iter_q;
    start_d   = start_q;
    end_d     = end_q;
    iters_d   = iters_q;
    last_d    = last_q;
    uop_vld_d = 1'b0;
    uop_d     = uop_q;
    uop_d.op  = '0;
    bit_idx_d = bit_idx_q;
    done_d    = 1'b0;
    issue     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          start_d = bus.cmd_start_pc;
          end_d   = bus.cmd_end_pc;
          iters_d = bus.cmd_iters;
          if (bus.cmd_iters == '0) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            issue = 1'b1;
          end
        end
      end
      RUN: begin
        // last_q means the final uop is on the outputs now
        if (last_q) begin
          state_d = FIN;
          done_d  = 1'b1;
        end else if (!bus.stall) begin
          issue = 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (issue) begin
      if (legal) begin
        state_d   = RUN;
        uop_vld_d = 1'b1;
        uop_d     = entry;
        bit_idx_d = cur_iter;
        last_d    = (cur_pc == end_d) && (cur_iter == iters_d - ITER_W'(1));
        if (cur_pc == end_d) begin
          pc_d   = start_d;
          iter_d = cur_iter + ITER_W'(1);
        end else begin
          pc_d   = cur_pc + PC_W'(1);
          iter_d = cur_iter;
        end
      end else begin
        state_d = FIN;
        done_d  = 1'b1;
      end
    end

    err_d = err_q | (issue & ~legal);
  end

  // State and registered outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      iter_q    <= '0;
      start_q   <= '0;
      end_q     <= '0;
      iters_q   <= '0;
      last_q    <= 1'b0;
      uop_vld_q <= 1'b0;
      uop_q     <= '0;
      bit_idx_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      iter_q    <= iter_d;
      start_q   <= start_d;
      end_q     <= end_d;
      iters_q   <= iters_d;
      last_q    <= last_d;
      uop_vld_q <= uop_vld_d;
      uop_q     <= uop_d;
      bit_idx_q <= bit_idx_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.uop_valid = uop_vld_q;
  assign bus.uop_rs1   = uop_q.rs1;
  assign bus.uop_rs2   = uop_q.rs2;
  assign bus.uop_rd    = uop_q.rd;
  assign bus.uop_op    = uop_q.op;
  assign bus.bit_idx   = bit_idx_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_bslu_ap_seq.sv
// Bench for bslu_ap_seq: directed scenarios plus randomized commands against a list-based model.
// Outputs are sampled at negedge; inputs are driven right after sampling.
// The model expands each command into its ordered (pc, bit) list and walks it cycle by cycle.
module tb_bslu_ap_seq;
  import bslu_ap_pkg::*;

  localparam int PC_W   = 4;
  localparam int ITER_W = 6;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bslu_ap_seq_if #(.PC_W(PC_W), .ITER_W(ITER_W)) bus ();

  bslu_ap_seq #(.PC_W(PC_W), .ITER_W(ITER_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          errors = 0;
  int          checks = 0;
  logic [14:0] prog_m [DEPTH];
  logic        exp_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // True when the sequencer is expected to refuse this entry
  function automatic bit would_abort(input logic [14:0] e);
`ifdef BSLU_AP_SEQ_ILLEGAL_CHK_EN
    logic [2:0] rd;
    logic [5:0] op;
    rd = e[8:6];
    op = e[5:0];
    return !(($countones(rd) == 1) &&
             ($countones({op[5], op[4], op[3], op[1], op[0]}) <= 1));
`else
    return (e === 15'bx);
`endif
  endfunction

  function automatic logic [14:0] rnd_entry();
    logic [2:0] a, b, d;
    logic [5:0] op;
    int         k;
    if ($urandom_range(0, 3) == 0) return 15'($urandom);
    a  = 3'(1 << $urandom_range(0, 2));
    b  = 3'(1 << $urandom_range(0, 2));
    d  = 3'(1 << $urandom_range(0, 2));
    k  = $urandom_range(0, 4);
    op = (6'($urandom_range(0, 63)) & 6'b000100) | 6'(1 << ((k < 2) ? k : k + 1));
    return {a, b, d, op};
  endfunction

  task automatic prog_write(input int addr, input logic [14:0] data);
    bus.prog_we   = 1'b1;
    bus.prog_addr = PC_W'(addr);
    bus.prog_data = data;
    prog_m[addr]  = data;
    @(negedge clk);
    bus.prog_we   = 1'b0;
  endtask

  // Issue one command and check every cycle until the sequencer is idle again.
  // rst_cyc>0 asserts rst during that run cycle and checks the reset response.
  task automatic run_cmd(input int s, input int e, input int n_it, input logic [63:0] stall_mask,
                         input bit rnd_stall, input int rst_cyc, output int done_cyc);
    int          pcs[$];
    int          its[$];
    int          len;
    int          idx;
    bit          prev_stall;
    bit          ended;
    logic [14:0] ent;
    len = ((e - s) & (DEPTH - 1)) + 1;
    for (int i = 0; i < n_it; i++)
      for (int k = 0; k < len; k++) begin
        pcs.push_back((s + k) % DEPTH);
        its.push_back(i);
      end
    done_cyc = -1;
    idx      = 0;
    ended    = 1'b0;
    check("ready_before_cmd", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid    = 1'b1;
    bus.cmd_start_pc = PC_W'(s);
    bus.cmd_end_pc   = PC_W'(e);
    bus.cmd_iters    = ITER_W'(n_it);
    bus.stall        = rnd_stall ? 1'($urandom_range(0, 1)) : stall_mask[0];
    prev_stall       = 1'b0;
    for (int c = 1; c < 400 && !ended; c++) begin
      @(negedge clk);
      if (rst_cyc != 0 && c == rst_cyc + 1) begin
        exp_err = 1'b0;
        check("rst_valid", 32'(bus.uop_valid), 32'd0);
        check("rst_op", 32'(bus.uop_op), 32'd0);
        check("rst_rd", 32'(bus.uop_rd), 32'd0);
        check("rst_bit_idx", 32'(bus.bit_idx), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_ready", 32'(bus.cmd_ready), 32'd1);
        rst   = 1'b0;
        ended = 1'b1;
      end else if (idx < pcs.size() && done_cyc < 0) begin
        if (c > 1 && prev_stall) begin
          check("stall_valid", 32'(bus.uop_valid), 32'd0);
          check("stall_op", 32'(bus.uop_op), 32'd0);
          check("stall_done", 32'(bus.done), 32'd0);
        end else begin
          ent = prog_m[pcs[idx]];
          if (would_abort(ent)) begin
            exp_err = 1'b1;
            check("illegal_valid", 32'(bus.uop_valid), 32'd0);
            check("illegal_op", 32'(bus.uop_op), 32'd0);
            check("illegal_done", 32'(bus.done), 32'd1);
            done_cyc = c;
            idx      = pcs.size();
          end else begin
            check("uop_valid", 32'(bus.uop_valid), 32'd1);
            check("uop_rs1", 32'(bus.uop_rs1), 32'(ent[14:12]));
            check("uop_rs2", 32'(bus.uop_rs2), 32'(ent[11:9]));
            check("uop_rd", 32'(bus.uop_rd), 32'(ent[8:6]));
            check("uop_op", 32'(bus.uop_op), 32'(ent[5:0]));
            check("bit_idx", 32'(bus.bit_idx), 32'(its[idx]));
            check("run_done", 32'(bus.done), 32'd0);
            idx++;
          end
        end
        check("run_ready", 32'(bus.cmd_ready), 32'd0);
      end else if (done_cyc < 0) begin
        check("fin_done", 32'(bus.done), 32'd1);
        check("fin_valid", 32'(bus.uop_valid), 32'd0);
        check("fin_op", 32'(bus.uop_op), 32'd0);
        check("fin_ready", 32'(bus.cmd_ready), 32'd0);
        done_cyc = c;
      end else begin
        check("idle_ready", 32'(bus.cmd_ready), 32'd1);
        check("idle_done", 32'(bus.done), 32'd0);
        check("idle_valid", 32'(bus.uop_valid), 32'd0);
        ended = 1'b1;
      end
      check("err", 32'(bus.err), 32'(exp_err));
      // Inputs for the next cycle: stray commands while busy must be ignored
      bus.cmd_valid    = ended ? 1'b0 : 1'($urandom_range(0, 1));
      bus.cmd_start_pc = PC_W'($urandom);
      bus.cmd_end_pc   = PC_W'($urandom);
      bus.cmd_iters    = ITER_W'($urandom);
      bus.stall        = rnd_stall ? ($urandom_range(0, 2) == 0) : stall_mask[c];
      prev_stall       = bus.stall;
      if (rst_cyc != 0 && c == rst_cyc) rst = 1'b1;
    end
    check("cmd_completed", 32'(ended), 32'd1);
    bus.cmd_valid = 1'b0;
    bus.stall     = 1'b0;
  endtask

  initial begin
    int dc;
    int ra;
    rst              = 1'b1;
    exp_err          = 1'b0;
    bus.prog_we      = 1'b0;
    bus.prog_addr    = '0;
    bus.prog_data    = '0;
    bus.cmd_valid    = 1'b0;
    bus.cmd_start_pc = '0;
    bus.cmd_end_pc   = '0;
    bus.cmd_iters    = '0;
    bus.stall        = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(bus.cmd_ready), 32'd1);
    check("reset_valid", 32'(bus.uop_valid), 32'd0);
    check("reset_op", 32'(bus.uop_op), 32'd0);
    check("reset_rs1", 32'(bus.uop_rs1), 32'd0);
    check("reset_rs2", 32'(bus.uop_rs2), 32'd0);
    check("reset_rd", 32'(bus.uop_rd), 32'd0);
    check("reset_bit_idx", 32'(bus.bit_idx), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_err", 32'(bus.err), 32'd0);
    rst = 1'b0;

    for (int a = 0; a < DEPTH; a++) prog_write(a, rnd_entry());
    prog_write(0, {REG_SA, 3'b000, REG_CR, 6'(1 << OP_MOV)});
    prog_write(1, {REG_CR, REG_PR, REG_SA, 6'(1 << OP_AND)});

    // Basic two-entry body, three bit-slices
    run_cmd(0, 1, 3, 64'd0, 1'b0, 0, dc);
    check("basic_done_cycle", 32'(dc), 32'd7);

    // Zero iterations: straight to done
    run_cmd(0, 1, 0, 64'd0, 1'b0, 0, dc);
    check("zero_iter_done_cycle", 32'(dc), 32'd1);

    // Body wrapping from the top of the store back to entry 0
    prog_write(15, {REG_PR, REG_SA, REG_PR, 6'(1 << OP_XNOR)});
    run_cmd(15, 0, 2, 64'd0, 1'b0, 0, dc);
    check("wrap_done_cycle", 32'(dc), 32'd5);

    // Two stalled cycles after the third uop
    run_cmd(0, 1, 3, 64'h18, 1'b0, 0, dc);
    check("stall_done_cycle", 32'(dc), 32'd9);

    // Reset in the fourth run cycle, then a clean rerun without reprogramming
    run_cmd(0, 1, 3, 64'd0, 1'b0, 4, dc);
    @(negedge clk);
    check("post_rst_done", 32'(bus.done), 32'd0);
    check("post_rst_valid", 32'(bus.uop_valid), 32'd0);
    run_cmd(0, 1, 3, 64'd0, 1'b0, 0, dc);
    check("rerun_done_cycle", 32'(dc), 32'd7);

    // Entry with a non-one-hot destination
    prog_write(1, {REG_CR, REG_PR, 3'b011, 6'(1 << OP_AND)});
    run_cmd(0, 1, 3, 64'd0, 1'b0, 0, dc);
`ifdef BSLU_AP_SEQ_ILLEGAL_CHK_EN
    check("illegal_done_cycle", 32'(dc), 32'd2);
    check("illegal_err_sticky", 32'(bus.err), 32'd1);
`else
    check("illegal_done_cycle", 32'(dc), 32'd7);
    check("illegal_err_sticky", 32'(bus.err), 32'd0);
`endif
    prog_write(1, {REG_CR, REG_PR, REG_SA, 6'(1 << OP_AND)});

    // Randomized programs, bodies, iteration counts and stalls
    for (int r = 0; r < 25; r++) begin
      ra = $urandom_range(0, DEPTH - 1);
      prog_write(ra, rnd_entry());
      run_cmd($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
              $urandom_range(0, 4), 64'd0, 1'b1, 0, dc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
